// File: rtl/mdu_ctrl.sv
// mdu_ctrl: RV32M multiply/divide sequencer beside the EX stage.
//
// Accepts one M-extension op at a time. Multiplies are issued to a shared
// external pipelined signed 33x33 multiplier; divides/remainders run on an
// internal radix-2 restoring divider (one quotient bit per cycle). The
// pipeline is held with `stall` until a one-cycle `done` strobe returns the
// 32-bit result.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   req_valid  EX holds a valid RV32M op
//   funct3     RV32M funct3 (MUL..REMU)
//   rs1_data   operand A / dividend
//   rs2_data   operand B / divisor
//   rd_addr    destination register, returned on result_rd
//   flush      abort the current op (redirect)
//   stall      combinational pipeline freeze
//   mult_a     registered extended operand A to the multiplier
//   mult_b     registered extended operand B to the multiplier
//   mult_p     multiplier product (two's complement)
//   done       registered one-cycle completion strobe
//   result     registered result, held until the next completion
//   result_rd  registered rd of the completed op
//
// State       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | waiting for req_valid; latches the op on acceptance
// S_MUL_WAIT  | operands at multiplier, counting down its pipeline latency
// S_DIV_RUN   | one restoring-divide iteration per cycle, 32 iterations
// S_DONE      | done strobe cycle; always returns to S_IDLE

module mdu_ctrl #(
  parameter int unsigned MULT_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  input  logic        flush,
  output logic        stall,
  output logic [32:0] mult_a,
  output logic [32:0] mult_b,
  input  logic [65:0] mult_p,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  result_rd
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_RUN  = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [5:0] DIV_ITERS = 6'd32;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic [32:0] mult_a_q, mult_a_d;
  logic [32:0] mult_b_q, mult_b_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  result_rd_q, result_rd_d;

  // ---------------------------------------------------------------------
  // Request decode (valid only while in S_IDLE with req_valid)
  // ---------------------------------------------------------------------
  logic        req_is_div;
  logic        req_signed_div;
  logic        req_div_zero;
  logic        req_div_ovf;
  logic [31:0] req_special_res;
  logic [31:0] rs1_abs;
  logic [31:0] rs2_abs;
  logic        ext_a_sign;
  logic        ext_b_sign;

  always_comb begin
    req_is_div     = funct3[2];
    // DIV (100) and REM (110) are signed; DIVU/REMU have funct3[0] set.
    req_signed_div = ~funct3[0];
    req_div_zero   = (rs2_data == 32'd0);
    req_div_ovf    = req_signed_div && (rs1_data == 32'h8000_0000) &&
                     (rs2_data == 32'hFFFF_FFFF);

    // Divide-by-zero takes precedence over overflow.
    if (req_div_zero) begin
      req_special_res = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
    end else begin
      req_special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // |0x80000000| stays 0x80000000, which is correct when read unsigned.
    rs1_abs = (req_signed_div && rs1_data[31]) ? (~rs1_data + 32'd1) : rs1_data;
    rs2_abs = (req_signed_div && rs2_data[31]) ? (~rs2_data + 32'd1) : rs2_data;

    // MUL/MULH/MULHSU treat A as signed; only MUL/MULH treat B as signed.
    ext_a_sign = (funct3 != F3_MULHU) && rs1_data[31];
    ext_b_sign = ((funct3 == F3_MUL) || (funct3 == F3_MULH)) && rs2_data[31];
  end

  // ---------------------------------------------------------------------
  // Restoring divider datapath: one iteration per cycle
  // ---------------------------------------------------------------------
  logic [33:0] div_shift;
  logic        div_ge;
  logic [32:0] div_diff;
  logic [32:0] div_rem_next;
  logic [31:0] div_dvd_next;
  logic [31:0] div_quo_final;
  logic [31:0] div_rem_final;

  always_comb begin
    div_shift     = {rem_q, dvd_q[31]};
    div_ge        = (div_shift >= {2'b00, dvs_q});
    div_diff      = div_shift[32:0] - {1'b0, dvs_q};
    div_rem_next  = div_ge ? div_diff : div_shift[32:0];
    // The dividend register doubles as the quotient shift register.
    div_dvd_next  = {dvd_q[30:0], div_ge};
    div_quo_final = neg_quo_q ? (~div_dvd_next + 32'd1) : div_dvd_next;
    div_rem_final = neg_rem_q ? (~div_rem_next[31:0] + 32'd1) : div_rem_next[31:0];
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    mult_a_d    = mult_a_q;
    mult_b_d    = mult_b_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_rd_d = result_rd_q;

    if (flush) begin
      // Abort silently: no done, result/result_rd untouched.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            f3_d = funct3;
            rd_d = rd_addr;
            if (!req_is_div) begin
              mult_a_d = {ext_a_sign, rs1_data};
              mult_b_d = {ext_b_sign, rs2_data};
              cnt_d    = 6'(MULT_LATENCY);
              state_d  = S_MUL_WAIT;
            end else if (req_div_zero || req_div_ovf) begin
              result_d    = req_special_res;
              result_rd_d = rd_addr;
              done_d      = 1'b1;
              state_d     = S_DONE;
            end else begin
              rem_d     = 33'd0;
              dvd_d     = rs1_abs;
              dvs_d     = rs2_abs;
              neg_quo_d = req_signed_div && (rs1_data[31] ^ rs2_data[31]);
              neg_rem_d = req_signed_div && rs1_data[31];
              cnt_d     = DIV_ITERS;
              state_d   = S_DIV_RUN;
            end
          end
        end

        S_MUL_WAIT: begin
          if (cnt_q == 6'd0) begin
            result_d    = (f3_q == F3_MUL) ? mult_p[31:0] : mult_p[63:32];
            result_rd_d = rd_q;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end

        S_DIV_RUN: begin
          rem_d = div_rem_next;
          dvd_d = div_dvd_next;
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            // funct3[1] selects REM/REMU over DIV/DIVU.
            result_d    = f3_q[1] ? div_rem_final : div_quo_final;
            result_rd_d = rd_q;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 6'd0;
      f3_q        <= 3'd0;
      rd_q        <= 5'd0;
      mult_a_q    <= 33'd0;
      mult_b_q    <= 33'd0;
      rem_q       <= 33'd0;
      dvd_q       <= 32'd0;
      dvs_q       <= 32'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 32'd0;
      result_rd_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_rd_q <= result_rd_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign stall = ~rst & (((state_q == S_IDLE) & req_valid & ~flush) |
                         (state_q == S_MUL_WAIT) |
                         (state_q == S_DIV_RUN));

  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_rd = result_rd_q;

  // Product bits above 63 carry no information for RV32M results.
  logic unused_mult_p_hi;
  assign unused_mult_p_hi = ^mult_p[65:64];

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl with a behavioural model
// of the external pipelined multiplier and an arithmetic reference model.

module tb_mdu_ctrl;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        stall;
  logic [32:0] mult_a;
  logic [32:0] mult_b;
  logic [65:0] mult_p;
  logic        done;
  logic [31:0] result;
  logic [4:0]  result_rd;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  mdu_ctrl #(.MULT_LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_addr   (rd_addr),
    .flush     (flush),
    .stall     (stall),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_p    (mult_p),
    .done      (done),
    .result    (result),
    .result_rd (result_rd)
  );

  always #5 clk = ~clk;

  // External multiplier: LAT register stages, signed 33x33 -> 66.
  logic signed [65:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= 66'($signed(mult_a)) * 66'($signed(mult_b));
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mult_p = mpipe[LAT-1];

  // ---------------------------------------------------------------------
  // Reference model (plain arithmetic)
  // ---------------------------------------------------------------------
  function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] pu;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    r  = 32'd0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (!f3[2]) return int'(LAT) + 2;
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op (called #1 after a posedge); returns #1 after the posedge
  // that ends the done cycle, with req_valid dropped.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    bit seen;
    logic ema_s, emb_s;
    ema_s = (f3 != 3'd3) ? a[31] : 1'b0;
    emb_s = (f3 == 3'd0 || f3 == 3'd1) ? b[31] : 1'b0;
    req_valid = 1'b1;
    funct3    = f3;
    rs1_data  = a;
    rs2_data  = b;
    rd_addr   = rd;
    seen      = 1'b0;
    for (int cyc = 0; cyc <= 64 && !seen; cyc++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check("done_cycle", 32'(cyc), 32'(exp_lat));
        check("result", result, exp_res);
        check("result_rd", 32'(result_rd), 32'(rd));
        check("stall_in_done", 32'(stall), 32'd0);
        last_res = exp_res;
        last_rd  = rd;
      end else begin
        if (cyc < exp_lat) check("stall_busy", 32'(stall), 32'd1);
        if (!f3[2] && (cyc == 1 || cyc == exp_lat - 1)) begin
          check("mult_a_ext", 32'(mult_a[32]), 32'(ema_s));
          check("mult_a", mult_a[31:0], a);
          check("mult_b_ext", 32'(mult_b[32]), 32'(emb_s));
          check("mult_b", mult_b[31:0], b);
        end
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected done in cycle %0d", exp_lat);
    end
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, int'(LAT) + 2};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, int'(LAT) + 2};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, int'(LAT) + 2};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, int'(LAT) + 2};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd11, 32'h0000_000E, 33};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd12, 32'h0000_0002, 33};
    vecs[8]  = '{3'd4, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd7, 32'd5,         32'd0,         5'd14, 32'h0000_0005, 1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1};
    vecs[12] = '{3'd0, 32'h0001_0003, 32'h0002_0005, 5'd31, 32'h000B_000F, int'(LAT) + 2};

    // Reset: request present, outputs must stay at reset values.
    rst       = 1'b1;
    req_valid = 1'b1;
    flush     = 1'b0;
    funct3    = 3'd0;
    rs1_data  = 32'd7;
    rs2_data  = 32'd3;
    rd_addr   = 5'd9;
    last_res  = 32'd0;
    last_rd   = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_result_rd", 32'(result_rd), 32'd0);
    check("rst_mult_a", mult_a[31:0], 32'd0);
    check("rst_mult_b", mult_b[31:0], 32'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 1'b0;

    // Directed table.
    for (int i = 0; i < 13; i++)
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp_res, vecs[i].exp_lat);

    // Flush in cycle 10 of a DIV, then a MUL presented in cycle 11.
    req_valid = 1'b1;
    funct3    = 3'd4;
    rs1_data  = 32'd1000;
    rs2_data  = 32'd3;
    rd_addr   = 5'd17;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) flush = 1'b1;
      @(negedge clk);
      check("flush_no_done", 32'(done), 32'd0);
      check("flush_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
    end
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("post_flush_stall", 32'(stall), 32'd0);
    check("post_flush_done", 32'(done), 32'd0);
    check("post_flush_result", result, last_res);
    check("post_flush_rd", 32'(result_rd), 32'(last_rd));
    #1;
    run_op(3'd0, 32'h0001_2345, 32'h0006_789A, 5'd3,
           ref_result(3'd0, 32'h0001_2345, 32'h0006_789A), int'(LAT) + 2);

    // Reset pulsed during MUL_WAIT.
    req_valid = 1'b1;
    funct3    = 3'd1;
    rs1_data  = 32'h8765_4321;
    rs2_data  = 32'h1234_5678;
    rd_addr   = 5'd22;
    @(negedge clk);
    check("rstmid_stall0", 32'(stall), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    check("rstmid_stall_in_rst", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_stall", 32'(stall), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_result", result, 32'd0);
    check("rstmid_result_rd", 32'(result_rd), 32'd0);
    check("rstmid_mult_a", mult_a[31:0], 32'd0);
    check("rstmid_mult_b", mult_b[31:0], 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rstmid_no_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    last_res = 32'd0;
    last_rd  = 5'd0;

    // Two queued ops back to back: MUL then DIVU.
    run_op(3'd0, 32'd1234, 32'd5678, 5'd1, 32'd7006652, int'(LAT) + 2);
    run_op(3'd5, 32'd1000000, 32'd37, 5'd2, 32'd27027, 33);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("queue_no_extra_done", 32'(done), 32'd0);
      check("queue_idle_stall", 32'(stall), 32'd0);
    end
    @(posedge clk); #1;

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [4:0]  rd;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      run_op(f3, a, b, rd, ref_result(f3, a, b), ref_latency(f3, a, b));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

RV32M multiply/divide sequencer sitting beside the EX stage. It accepts one M-extension operation at a time and drives the shared external pipelined signed 33x33 multiplier for MUL/MULH/MULHSU/MULHU. It runs DIV/DIVU/REM/REMU on an internal radix-2 restoring divider. It holds the pipeline with `stall` until the 32-bit result is returned with a one-cycle `done` strobe.

## Interface
- `MULT_LATENCY`, default 2: register stages in the external multiplier from `mult_a`/`mult_b` to `mult_p`; legal range 1..15.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  EX holds a valid RV32M op (opcode OP_R, funct7[0]=1).
- `funct3`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data`  in  32  operand A / dividend.
- `rs2_data`  in  32  operand B / divisor.
- `rd_addr`  in  5  destination register, returned on `result_rd`.
- `flush`  in  1  abort the current op (branch/jump redirect).
- `stall`  out  1  combinational; freeze PC/IF/ID/EX.
- `mult_a`  out  33  registered, extended operand A to the multiplier.
- `mult_b`  out  33  registered, extended operand B to the multiplier.
- `mult_p`  in  66  multiplier product, two's complement.
- `done`  out  1  registered; result valid for exactly this cycle.
- `result`  out  32  registered; held until the next completion.
- `result_rd`  out  5  registered; rd of the completed op.

## Operation
- States: IDLE, MUL_WAIT, DIV_RUN, DONE.
- **IDLE, flush=0, req_valid=1:** latch funct3 and rd_addr.
- **IDLE, multiply (funct3[2]=0):**
  - Load `mult_a`/`mult_b` with the extended operands.
  - Extension: MUL/MULH sign-extend both operands; MULHSU sign-extends A and zero-extends B; MULHU zero-extends both.
  - Load wait counter with MULT_LATENCY; go to MUL_WAIT.
- **MUL_WAIT:**
  - Decrement the counter each cycle.
  - When the counter is 0, capture `result` = mult_p[31:0] for MUL, else mult_p[63:32]; go to DONE.
  - `mult_a`/`mult_b` are held stable throughout.
- **IDLE, divide (funct3[2]=1), special cases:** resolve immediately and go to DONE.
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- **IDLE, divide, normal case:**
  - Signed ops load |rs1|, |rs2| and record sign_q = rs1[31]^rs2[31] and sign_r = rs1[31].
  - Unsigned ops load the operands raw.
  - Clear the 33-bit partial remainder, set iteration count to 32, go to DIV_RUN.
- **DIV_RUN:**
  - Each cycle: shift {rem, dividend} left by 1, trial-subtract the divisor, keep the result if non-negative, shift in the quotient bit.
  - After iteration 32, select quotient (DIV/DIVU) or remainder (REM/REMU).
  - Negate the quotient if sign_q; negate the remainder if sign_r (signed ops only).
  - Write `result`; go to DONE.
- **DONE:** `done`=1, `result_rd`=latched rd; unconditionally go to IDLE.
- `stall` = !rst & ((IDLE & req_valid & !flush) | MUL_WAIT | DIV_RUN); `stall`=0 in DONE.
- Handshake with EX:
  - EX keeps req_valid/operands stable while `stall`=1.
  - EX advances on the `done` cycle, so the same instruction is never re-accepted.
- **Flush:** any state goes to IDLE next cycle. No `done` is produced; `result`/`result_rd` are left unchanged. In IDLE, flush has priority over req_valid.
- **Reset values:** state IDLE, counters 0, `mult_a`/`mult_b`=0, `done`=0, `result`=0, `result_rd`=0, `stall`=0.
- **Reset mid-operation:** discards the op silently, same as flush.

## Timing
- Cycle 0 is the IDLE cycle in which the request is accepted.
- **Multiply:**
  - `mult_a`/`mult_b` valid from cycle 1.
  - MUL_WAIT occupies cycles 1..MULT_LATENCY+1.
  - `done` in cycle MULT_LATENCY+2 (4 for the default).
  - `stall` high in cycles 0..MULT_LATENCY+1.
- **Divide, normal case:** DIV_RUN occupies cycles 1..32; `done` in cycle 33; `stall` high in cycles 0..32.
- **Divide, special case:** `done` in cycle 1; `stall` high in cycle 0 only.
- **Back-to-back ops:** a new request is accepted at the earliest in the cycle after `done` (IDLE), giving one bubble between M-ops.
- `done` never asserts in two consecutive cycles.

## Test plan
- MUL 0x00000007 x 0xFFFFFFFD, MULT_LATENCY=2 -> `stall` high cycles 0-3; `done` cycle 4; result 0xFFFFFFEB; result_rd = issued rd.
- 0xFFFFFFFF x 0xFFFFFFFF:
  - MULHU -> 0xFFFFFFFE.
  - MULH -> 0x00000000.
  - MULHSU -> 0xFFFFFFFF.
  - Also check `mult_a`/`mult_b` extension bits, e.g. MULHSU gives mult_b[32]=0.
- Signed and unsigned divide:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, `done` cycle 33.
  - REM of the same -> 0xFFFFFFFF.
  - DIVU 100/7 -> 0x0000000E.
  - REMU 100/7 -> 0x00000002.
- Divide special cases:
  - DIV 5/0 -> 0xFFFFFFFF with `done` cycle 1.
  - REMU 5/0 -> 0x00000005.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM of the same -> 0x00000000.
- Flush asserted in cycle 10 of a DIV -> no `done`, `stall` low and state IDLE in cycle 11. A MUL presented in cycle 11 completes normally in cycle 15.
- `rst` pulsed during MUL_WAIT -> next cycle all outputs at reset values and `stall`=0. Two queued ops (MUL then DIVU) -> each accepted exactly once, with `done` pulses separated by the required idle cycle.
